// File: rtl/mips_multicycle_control.sv
// Sequenced multi-cycle controller for the mips CPU: one state register,
// Moore-decoded control outputs with memory-ready and branch-zero gating.
module mips_multicycle_control #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit SUPPORT_BNE   = 1'b1,
    parameter bit SUPPORT_ADDI  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_WB   = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t cur;
    state_t nxt;
    logic   ready;
    logic   opcode_legal;

    // Without the handshake mem_ready never reaches the logic, so X on it cannot leak out.
    always_comb begin
        ready = 1'b1;
        if (MEM_HANDSHAKE)
            ready = mem_ready;
    end

    always_comb begin
        case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL: opcode_legal = 1'b1;
            OP_BNE:  opcode_legal = SUPPORT_BNE;
            OP_ADDI: opcode_legal = SUPPORT_ADDI;
            default: opcode_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            cur <= FETCH;
        else
            cur <= nxt;
    end

    always_comb begin
        nxt        = FETCH;
        pc_en      = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = '0;
        mem_to_reg = '0;
        alu_src_a  = 1'b0;
        alu_src_b  = '0;
        alu_op     = '0;
        pc_source  = '0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        state      = '0;
        if (!reset) begin
            state = cur;
            case (cur)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = ready;
                    pc_en     = ready;
                    nxt       = ready ? DECODE : FETCH;
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    if (!opcode_legal) begin
                        illegal_op = 1'b1;
                        nxt        = FETCH;
                    end else begin
                        case (opcode)
                            OP_RTYPE:              nxt = EXECUTE;
                            OP_LW, OP_SW, OP_ADDI: nxt = MEM_ADDR;
                            OP_BEQ, OP_BNE:        nxt = BRANCH;
                            OP_J, OP_JAL:          nxt = JUMP;
                            default:               nxt = FETCH;
                        endcase
                    end
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    case (opcode)
                        OP_LW:   nxt = MEM_READ;
                        OP_SW:   nxt = MEM_WRITE;
                        OP_ADDI: nxt = ADDI_WB;
                        default: nxt = FETCH;
                    endcase
                end
                MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    nxt      = ready ? MEM_WB : MEM_READ;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'b01;
                    instr_done = 1'b1;
                end
                MEM_WRITE: begin
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = ready;
                    nxt        = ready ? FETCH : MEM_WRITE;
                end
                EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                    nxt       = R_WB;
                end
                R_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b01;
                    instr_done = 1'b1;
                end
                ADDI_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = 2'b01;
                    pc_source  = 2'b01;
                    instr_done = 1'b1;
                    pc_en      = (opcode == OP_BNE) ? ~zero : zero;
                end
                JUMP: begin
                    pc_source  = 2'b10;
                    pc_en      = 1'b1;
                    instr_done = 1'b1;
                    if (opcode == OP_JAL) begin
                        reg_write  = 1'b1;
                        reg_dst    = 2'b10;
                        mem_to_reg = 2'b10;
                    end
                end
                default: nxt = FETCH;
            endcase
        end
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multi-cycle controller FSM; the next-generation control block for the `mips` CPU.
- Replaces the single-cycle opcode decoder with a sequenced controller. Each instruction executes over 3–5 states (more with memory wait cycles) on a shared ALU/memory datapath.
- Adds support for `bne` and `addi`, an optional memory-ready handshake, and instruction-done and illegal-opcode reporting.

Parameters:
- MEM_HANDSHAKE, default 1: 1 = FETCH/MEM_READ/MEM_WRITE wait for mem_ready; 0 = mem_ready ignored, memory completes in one cycle.
- SUPPORT_BNE, default 1: 0 = opcode 0x05 treated as illegal.
- SUPPORT_ADDI, default 1: 0 = opcode 0x08 treated as illegal.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]; stable from DECODE until the instruction ends
- zero  in  1  ALU zero flag, valid in BRANCH
- mem_ready  in  1  memory access complete this cycle
- pc_en  out  1  PC register load enable (branch condition resolved internally)
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load enable
- reg_write  out  1  register file write enable
- reg_dst  out  2  write register select: 00 = rt, 01 = rd, 10 = $31
- mem_to_reg  out  2  write data select: 00 = ALUOut, 01 = MDR, 10 = PC
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU B select: 00 = register B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded
- pc_source  out  2  PC input select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- illegal_op  out  1  one-cycle pulse in DECODE when the opcode is unsupported
- state  out  4  current state, for debug

Behaviour:
- Reset: synchronous. state <= FETCH at the clock edge where reset = 1. While reset = 1, all outputs are combinationally forced to 0. The first cycle after reset deasserts is FETCH.
- Outputs are Moore (decoded from state). Exceptions: pc_en in BRANCH depends on zero; handshake gating as stated under FETCH/MEM_READ/MEM_WRITE. Signals not listed for a state are 0.
- State encoding (decimal): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_WB 10. Codes 11–15: all outputs 0, next state FETCH.
- FETCH:
  - Asserts mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - ir_write and pc_en are asserted only when ready, where ready = mem_ready | ~MEM_HANDSHAKE.
  - Next state: DECODE if ready, else stay in FETCH (mem_read stays high).
- DECODE:
  - Asserts alu_src_a = 0, alu_src_b = 11, alu_op = 00.
  - Next state by opcode: 0x00 → EXECUTE; 0x23 / 0x2B / 0x08 → MEM_ADDR; 0x04 / 0x05 → BRANCH; 0x02 / 0x03 → JUMP.
  - Any other opcode, or a disabled optional opcode: illegal_op = 1, next state FETCH.
- MEM_ADDR:
  - Asserts alu_src_a = 1, alu_src_b = 10, alu_op = 00.
  - Next state: 0x23 → MEM_READ; 0x2B → MEM_WRITE; 0x08 → ADDI_WB.
- MEM_READ:
  - Asserts mem_read = 1, i_or_d = 1.
  - Next state: MEM_WB if ready, else stay.
- MEM_WB: reg_write = 1, reg_dst = 00, mem_to_reg = 01, instr_done = 1. Next state FETCH.
- MEM_WRITE:
  - Asserts mem_write = 1, i_or_d = 1.
  - If ready: instr_done = 1, next state FETCH. Otherwise stay with mem_write held high; the memory must tolerate a repeated write of the same data.
- EXECUTE: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Next state R_WB.
- R_WB: reg_write = 1, reg_dst = 01, mem_to_reg = 00, instr_done = 1. Next state FETCH.
- ADDI_WB: reg_write = 1, reg_dst = 00, mem_to_reg = 00, instr_done = 1. Next state FETCH.
- BRANCH:
  - Asserts alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_source = 01, instr_done = 1.
  - pc_en = zero for opcode 0x04; pc_en = ~zero for opcode 0x05.
  - Next state FETCH.
- JUMP:
  - Asserts pc_source = 10, pc_en = 1, instr_done = 1.
  - For opcode 0x03 additionally: reg_write = 1, reg_dst = 10, mem_to_reg = 10. The PC already holds PC+4 from FETCH.
  - Next state FETCH.
- Latency with MEM_HANDSHAKE = 0: R-type 4, lw 5, sw 4, addi 4, beq/bne 3, j/jal 3 cycles. Each cycle that mem_ready = 0 in a wait state adds one cycle.
- Reset mid-instruction (including mid-wait) abandons the instruction. No reg_write or mem_write is asserted in the reset cycle.
- When MEM_HANDSHAKE = 0, mem_ready is fully ignored; X on mem_ready must not propagate to any output.

Test Plan:
- reset held 3 cycles with opcode = 0x23 → all outputs 0 during reset; cycle after release: state = 0, mem_read = 1, alu_src_b = 01.
- lw (0x23), MEM_HANDSHAKE = 1, mem_ready low for 2 cycles in FETCH and 1 in MEM_READ → state sequence 0,0,0,1,2,3,3,4. ir_write/pc_en only on the third FETCH cycle. instr_done only in state 4 with mem_to_reg = 01.
- beq (0x04) with zero = 1 → pc_en = 1 in BRANCH; bne (0x05) with zero = 1 → pc_en = 0; bne with zero = 0 → pc_en = 1. Each takes 3 cycles, pc_source = 01.
- jal (0x03) → JUMP has reg_write = 1, reg_dst = 10, mem_to_reg = 10, pc_en = 1. j (0x02) → same state with reg_write = 0.
- opcode 0x3F, and 0x08 with SUPPORT_ADDI = 0 → illegal_op pulses in DECODE, next state FETCH, no reg_write/mem_write. With SUPPORT_ADDI = 1, 0x08 → states 0,1,2,10 with reg_dst = 00.
- reset asserted while in MEM_WRITE with mem_ready = 0 → mem_write = 0 in the reset cycle; state = 0 the next cycle. Random opcode/mem_ready sequences → state never reaches 11–15 and instr_done count matches the number of instructions retired.
